yutorina_bus_if: RTL and testbench

Master-side bus interface that connects one CPU memory stage (instruction fetch or memory access) to one master port of the shared YutorinaCPU bus. It turns a single-cycle access strobe from the pipeline into the full request, grant, address-strobe and ready handshake. It holds the pipeline busy until the bus cycle completes, latches read data and reports a bus timeout. One instance per bus master, placed directly upstream of the bus arbiter and master multiplexer.

---
 rtl/yutorina_bus_if.sv | 175 +++++++++++++++++
 tb/tb_yutorina_bus_if.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/yutorina_bus_if.sv
// -----------------------------------------------------------------------------
// yutorina_bus_if
//
// Master-side bus interface between one CPU memory stage (instruction fetch or
// memory access) and one master port of the shared YutorinaCPU bus. It turns a
// single-cycle access strobe from the pipeline into the full request / grant /
// address-strobe / ready handshake. It keeps the pipeline busy until the bus
// cycle finishes, latches read data and flags a bus timeout.
//
// Parameters
//   TIMEOUT     ACCESS cycles without bus_rdy_ before the cycle is abandoned
//               (1..255; the counter is 8 bits wide).
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous active-low reset
//   stall       pipeline stall; holds DONE while high
//   flush       pipeline flush; cancels a request that has not been granted
//   addr        word address from the pipeline
//   as_         active-low access strobe from the pipeline (sampled in IDLE)
//   rw          access direction, 1 = read, 0 = write
//   w_data      write data from the pipeline
//   r_data      latched read data (registered)
//   busy        pipeline stall request (combinational)
//   err         completed cycle timed out (registered)
//   bus_req_    active-low bus request to the arbiter
//   bus_grnt_   active-low grant from the arbiter
//   bus_addr    address to the master mux
//   bus_as_     active-low address strobe to the master mux
//   bus_rw      direction to the master mux
//   bus_w_data  write data to the master mux
//   bus_r_data  read data from the slave mux
//   bus_rdy_    active-low ready from the slave mux
// -----------------------------------------------------------------------------
module yutorina_bus_if #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [29:0] addr,
  input  logic        as_,
  input  logic        rw,
  input  logic [31:0] w_data,
  output logic [31:0] r_data,
  output logic        busy,
  output logic        err,
  output logic        bus_req_,
  input  logic        bus_grnt_,
  output logic [29:0] bus_addr,
  output logic        bus_as_,
  output logic        bus_rw,
  output logic [31:0] bus_w_data,
  input  logic [31:0] bus_r_data,
  input  logic        bus_rdy_
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_e;

  // Counter value at which the last permitted ACCESS cycle is sampled.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_e      state_q;
  logic [7:0]  cnt_q;
  logic [31:0] r_data_q;
  logic        err_q;
  logic        bus_req_q;
  logic [29:0] bus_addr_q;
  logic        bus_as_q;
  logic        bus_rw_q;
  logic [31:0] bus_w_data_q;

  // ---------------------------------------------------------------------------
  // Handshake FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      r_data_q     <= '0;
      err_q        <= 1'b0;
      bus_req_q    <= 1'b1;
      bus_addr_q   <= '0;
      bus_as_q     <= 1'b1;
      bus_rw_q     <= 1'b1;
      bus_w_data_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!as_ && !flush) begin
            // The bus_* attribute registers keep this access until the next
            // accepted one, so they double as the request holding registers.
            bus_addr_q   <= addr;
            bus_rw_q     <= rw;
            bus_w_data_q <= w_data;
            bus_req_q    <= 1'b0;
            state_q      <= REQ;
          end
        end

        REQ: begin
          // Flush wins over a simultaneous grant: nothing has been issued yet.
          if (flush) begin
            bus_req_q <= 1'b1;
            state_q   <= IDLE;
          end else if (!bus_grnt_) begin
            bus_as_q <= 1'b0;
            cnt_q    <= '0;
            state_q  <= ACCESS;
          end
        end

        ACCESS: begin
          // Strobe is a single-cycle pulse; flush and grant are ignored here.
          bus_as_q <= 1'b1;
          if (!bus_rdy_) begin
            if (bus_rw_q) begin
              r_data_q <= bus_r_data;
            end
            bus_req_q <= 1'b1;
            err_q     <= 1'b0;
            state_q   <= DONE;
          end else if (cnt_q == CNT_LAST) begin
            r_data_q  <= '0;
            err_q     <= 1'b1;
            bus_req_q <= 1'b1;
            state_q   <= DONE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end

        DONE: begin
          if (!stall) begin
            err_q   <= 1'b0;
            state_q <= IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Pipeline busy: asserted as soon as a strobe is accepted, released in DONE
  // ---------------------------------------------------------------------------
  always_comb begin
    busy = 1'b0;
    case (state_q)
      IDLE:    busy = ~as_ & ~flush;
      REQ:     busy = 1'b1;
      ACCESS:  busy = 1'b1;
      DONE:    busy = 1'b0;
      default: busy = 1'b0;
    endcase
  end

  assign r_data     = r_data_q;
  assign err        = err_q;
  assign bus_req_   = bus_req_q;
  assign bus_addr   = bus_addr_q;
  assign bus_as_    = bus_as_q;
  assign bus_rw     = bus_rw_q;
  assign bus_w_data = bus_w_data_q;

endmodule

// File: tb/tb_yutorina_bus_if.sv
// -----------------------------------------------------------------------------
// tb_yutorina_bus_if
//
// Directed, table-driven bench for yutorina_bus_if (TIMEOUT = 4). Each table
// row is one clock cycle: inputs are applied on the falling edge, busy is
// checked 1 time unit later, and the registered outputs are checked on the
// following falling edge. Hand-written sequences cover the request-length
// count with write data hold and an asynchronous reset in the middle of ACCESS.
// -----------------------------------------------------------------------------
module tb_yutorina_bus_if;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic [29:0] addr;
  logic        as_;
  logic        rw;
  logic [31:0] w_data;
  logic [31:0] r_data;
  logic        busy;
  logic        err;
  logic        bus_req_;
  logic        bus_grnt_;
  logic [29:0] bus_addr;
  logic        bus_as_;
  logic        bus_rw;
  logic [31:0] bus_w_data;
  logic [31:0] bus_r_data;
  logic        bus_rdy_;

  int compared;
  int mismatched;

  yutorina_bus_if #(.TIMEOUT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .flush      (flush),
    .addr       (addr),
    .as_        (as_),
    .rw         (rw),
    .w_data     (w_data),
    .r_data     (r_data),
    .busy       (busy),
    .err        (err),
    .bus_req_   (bus_req_),
    .bus_grnt_  (bus_grnt_),
    .bus_addr   (bus_addr),
    .bus_as_    (bus_as_),
    .bus_rw     (bus_rw),
    .bus_w_data (bus_w_data),
    .bus_r_data (bus_r_data),
    .bus_rdy_   (bus_rdy_)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        as_n;
    logic        fl;
    logic        st;
    logic        rw;
    logic        gnt_n;
    logic        rdy_n;
    logic [29:0] a;
    logic [31:0] wd;
    logic [31:0] rdin;
    logic        e_busy;
    logic        e_req_n;
    logic        e_as_n;
    logic        e_err;
    logic [31:0] e_rd;
    logic [29:0] e_addr;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(
    input logic as_n, input logic fl, input logic st, input logic rwi,
    input logic gnt_n, input logic rdy_n,
    input logic [29:0] a, input logic [31:0] wd, input logic [31:0] rdin,
    input logic e_busy, input logic e_req_n, input logic e_as_n,
    input logic e_err, input logic [31:0] e_rd, input logic [29:0] e_addr);
    vec_t v;
    v.as_n = as_n;   v.fl = fl;        v.st = st;        v.rw = rwi;
    v.gnt_n = gnt_n; v.rdy_n = rdy_n;  v.a = a;          v.wd = wd;
    v.rdin = rdin;   v.e_busy = e_busy; v.e_req_n = e_req_n;
    v.e_as_n = e_as_n; v.e_err = e_err; v.e_rd = e_rd;   v.e_addr = e_addr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    as_ = 1'b1; flush = 1'b0; stall = 1'b0; rw = 1'b1;
    bus_grnt_ = 1'b1; bus_rdy_ = 1'b1; addr = '0; w_data = '0;
    bus_r_data = '0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_req_n"},  {31'd0, bus_req_}, 32'd1);
    chk({tag, "_as_n"},   {31'd0, bus_as_},  32'd1);
    chk({tag, "_addr"},   {2'd0, bus_addr},  32'd0);
    chk({tag, "_rw"},     {31'd0, bus_rw},   32'd1);
    chk({tag, "_wdata"},  bus_w_data,        32'd0);
    chk({tag, "_rdata"},  r_data,            32'd0);
    chk({tag, "_err"},    {31'd0, err},      32'd0);
    chk({tag, "_busy"},   {31'd0, busy},     32'd0);
  endtask

  localparam logic [31:0] DB = 32'hDEADBEEF;
  localparam logic [31:0] BF = 32'h0BADF00D;
  localparam logic [31:0] S2 = 32'h11112222;
  localparam logic [31:0] A5 = 32'h5A5A5A5A;

  initial begin
    int req_low;
    logic wd_ok;

    compared   = 0;
    mismatched = 0;
    rst = 1'b0;
    idle_inputs();

    // Read, immediate grant, ready on first ACCESS cycle
    vt.push_back(mk(0,0,0,1,1,1,30'h100,0,0,            1,0,1,0,0, 30'h100));
    vt.push_back(mk(1,0,0,1,0,1,0,0,0,                  1,0,0,0,0, 30'h100));
    vt.push_back(mk(1,0,0,1,1,0,0,0,DB,                 1,1,1,0,DB,30'h100));
    vt.push_back(mk(1,0,0,1,1,1,0,0,0,                  0,1,1,0,DB,30'h100));
    vt.push_back(mk(1,0,0,1,1,1,0,0,0,                  0,1,1,0,DB,30'h100));
    // Write, grant on 5th REQ cycle, ready on 2nd ACCESS cycle; r_data kept
    vt.push_back(mk(0,0,0,0,1,1,30'h2AB,32'h12345678,0, 1,0,1,0,DB,30'h2AB));
    for (int unsigned i = 0; i < 4; i++)
      vt.push_back(mk(1,0,0,0,1,1,0,0,0,                1,0,1,0,DB,30'h2AB));
    vt.push_back(mk(1,0,0,0,0,1,0,0,0,                  1,0,0,0,DB,30'h2AB));
    vt.push_back(mk(1,0,0,0,1,1,0,0,0,                  1,0,1,0,DB,30'h2AB));
    vt.push_back(mk(1,0,0,0,1,0,0,0,32'hCAFEF00D,       1,1,1,0,DB,30'h2AB));
    vt.push_back(mk(1,0,0,1,1,1,0,0,0,                  0,1,1,0,DB,30'h2AB));
    // Flush in REQ together with a grant; then flush blocks a strobe in IDLE
    vt.push_back(mk(0,0,0,1,1,1,30'h3C0,0,0,            1,0,1,0,DB,30'h3C0));
    vt.push_back(mk(1,1,0,1,0,1,0,0,0,                  1,1,1,0,DB,30'h3C0));
    vt.push_back(mk(1,0,0,1,1,1,0,0,0,                  0,1,1,0,DB,30'h3C0));
    vt.push_back(mk(0,1,0,1,1,1,30'h3FF,0,0,            0,1,1,0,DB,30'h3C0));
    // Flush in ACCESS does not abort the cycle
    vt.push_back(mk(0,0,0,1,1,1,30'h055,0,0,            1,0,1,0,DB,30'h055));
    vt.push_back(mk(1,0,0,1,0,1,0,0,0,                  1,0,0,0,DB,30'h055));
    vt.push_back(mk(1,1,0,1,1,1,0,0,0,                  1,0,1,0,DB,30'h055));
    vt.push_back(mk(1,1,0,1,0,0,0,0,BF,                 1,1,1,0,BF,30'h055));
    vt.push_back(mk(1,0,0,1,1,1,0,0,0,                  0,1,1,0,BF,30'h055));
    // Stall in DONE for 3 cycles while a new strobe is offered
    vt.push_back(mk(0,0,0,1,1,1,30'h077,0,0,            1,0,1,0,BF,30'h077));
    vt.push_back(mk(1,0,0,1,0,1,0,0,0,                  1,0,0,0,BF,30'h077));
    vt.push_back(mk(1,0,1,1,1,0,0,0,S2,                 1,1,1,0,S2,30'h077));
    for (int unsigned i = 0; i < 3; i++)
      vt.push_back(mk(0,0,1,1,1,1,30'h099,0,0,          0,1,1,0,S2,30'h077));
    vt.push_back(mk(0,0,0,1,1,1,30'h099,0,0,            0,1,1,0,S2,30'h077));
    vt.push_back(mk(1,0,0,1,1,1,0,0,0,                  0,1,1,0,S2,30'h077));
    // Timeout (4 ACCESS cycles), err held under stall, cleared on exit
    vt.push_back(mk(0,0,0,1,1,1,30'h1FF,0,0,            1,0,1,0,S2,30'h1FF));
    vt.push_back(mk(1,0,0,1,0,1,0,0,0,                  1,0,0,0,S2,30'h1FF));
    for (int unsigned i = 0; i < 3; i++)
      vt.push_back(mk(1,0,0,1,1,1,0,0,0,                1,0,1,0,S2,30'h1FF));
    vt.push_back(mk(1,0,0,1,1,1,0,0,0,                  1,1,1,1,0, 30'h1FF));
    vt.push_back(mk(1,0,1,1,1,1,0,0,0,                  0,1,1,1,0, 30'h1FF));
    vt.push_back(mk(1,0,0,1,1,1,0,0,0,                  0,1,1,0,0, 30'h1FF));
    vt.push_back(mk(1,0,0,1,1,1,0,0,0,                  0,1,1,0,0, 30'h1FF));
    // Ready on the last ACCESS cycle before timeout: success, no err
    vt.push_back(mk(0,0,0,1,1,1,30'h222,0,0,            1,0,1,0,0, 30'h222));
    vt.push_back(mk(1,0,0,1,0,1,0,0,0,                  1,0,0,0,0, 30'h222));
    for (int unsigned i = 0; i < 3; i++)
      vt.push_back(mk(1,0,0,1,1,1,0,0,0,                1,0,1,0,0, 30'h222));
    vt.push_back(mk(1,0,0,1,1,0,0,0,A5,                 1,1,1,0,A5,30'h222));
    vt.push_back(mk(1,0,0,1,1,1,0,0,0,                  0,1,1,0,A5,30'h222));

    // Reset state
    @(negedge clk);
    #1 check_reset_values("init");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    foreach (vt[i]) begin
      as_ = vt[i].as_n;  flush = vt[i].fl;  stall = vt[i].st;  rw = vt[i].rw;
      bus_grnt_ = vt[i].gnt_n;  bus_rdy_ = vt[i].rdy_n;
      addr = vt[i].a;  w_data = vt[i].wd;  bus_r_data = vt[i].rdin;
      #1 chk($sformatf("v%0d_busy", i), {31'd0, busy}, {31'd0, vt[i].e_busy});
      @(negedge clk);
      chk($sformatf("v%0d_req_n", i), {31'd0, bus_req_}, {31'd0, vt[i].e_req_n});
      chk($sformatf("v%0d_as_n", i),  {31'd0, bus_as_},  {31'd0, vt[i].e_as_n});
      chk($sformatf("v%0d_err", i),   {31'd0, err},      {31'd0, vt[i].e_err});
      chk($sformatf("v%0d_rdata", i), r_data,            vt[i].e_rd);
      chk($sformatf("v%0d_addr", i),  {2'd0, bus_addr},  {2'd0, vt[i].e_addr});
    end

    // Write with delayed grant: count request-low cycles, data held throughout
    idle_inputs();
    as_ = 1'b0; rw = 1'b0; addr = 30'h0AA; w_data = 32'h12345678;
    @(negedge clk);
    idle_inputs();
    req_low = 0;
    wd_ok   = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      if (bus_req_ !== 1'b0) break;
      req_low++;
      if (bus_w_data !== 32'h12345678 || bus_rw !== 1'b0) wd_ok = 1'b0;
      bus_grnt_ = (i == 5) ? 1'b0 : 1'b1;
      bus_rdy_  = (i == 7) ? 1'b0 : 1'b1;
      bus_r_data = 32'hFFFFFFFF;
      @(negedge clk);
    end
    chk("wr_req_low_cycles", req_low, 7);
    chk("wr_wdata_held", {31'd0, wd_ok}, 32'd1);
    chk("wr_rdata_unchanged", r_data, A5);
    chk("wr_wdata_after", bus_w_data, 32'h12345678);
    idle_inputs();
    @(negedge clk);

    // Asynchronous reset between edges while in ACCESS
    as_ = 1'b0; rw = 1'b0; addr = 30'h333; w_data = 32'hFFFF0000;
    @(negedge clk);
    idle_inputs();
    bus_grnt_ = 1'b0;
    @(negedge clk);
    idle_inputs();
    chk("rst_pre_as_n", {31'd0, bus_as_}, 32'd0);
    @(posedge clk);
    #2;
    chk("rst_pre_req_n", {31'd0, bus_req_}, 32'd0);
    chk("rst_pre_busy", {31'd0, busy}, 32'd1);
    rst = 1'b0;
    #1 check_reset_values("arst");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_req_n", {31'd0, bus_req_}, 32'd1);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Global time bound so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
